// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the two-port line memory arbiter.
package mem_arbiter_pkg;
   localparam int LINE_W          = 256;
   localparam int ADDR_W          = 27;
   localparam int BE_W            = 32;
   localparam int CNT_W           = 8;
   localparam int DEFAULT_ENTRIES = 256;
   localparam int DEFAULT_TIMEOUT = 15;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_WR_WAIT  = 3'd4,
      ST_RESP     = 3'd5
   } state_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the side not granted last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two line requesters onto one memory port, one transaction in flight,
// with per-transaction timeout and out-of-range rejection.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ENTRIES = DEFAULT_ENTRIES,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [BE_W-1:0]   m0_be,
   input  logic [LINE_W-1:0] m0_wdata,
   output logic              m0_resp,
   output logic              m0_err,
   output logic [LINE_W-1:0] m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [BE_W-1:0]   m1_be,
   input  logic [LINE_W-1:0] m1_wdata,
   output logic              m1_resp,
   output logic              m1_err,
   output logic [LINE_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_a,
   output logic [BE_W-1:0]   mem_be,
   output logic [LINE_W-1:0] mem_wd,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [LINE_W-1:0] mem_rd,
   input  logic              mem_valid,
   input  logic              mem_ready,
   output logic              err_sticky,
   output logic [2:0]        state_dbg
);
   localparam logic [ADDR_W:0] ENTRIES_L   = ENTRIES[ADDR_W:0];
   localparam int              WAIT_LAST_I = TIMEOUT - 1;
   localparam logic [CNT_W-1:0] WAIT_LAST  = WAIT_LAST_I[CNT_W-1:0];

   state_t            state;
   logic              owner_q;
   logic              last_grant;
   logic              rst_hold;
   logic [ADDR_W-1:0] addr_q;
   logic [BE_W-1:0]   be_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] rdata_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic [1:0]        beat;
   logic [1:0]        resp_q;
   logic [1:0]        err_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              err_sticky_q;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              g_write;
   logic [ADDR_W-1:0] g_addr;
   logic              g_in_range;

   // Handshake: a request transfers on a rising edge where mN_valid && mN_ready are both high;
   // ready only rises in IDLE, for the granted side, and never in the cycle after reset.
   assign req = {m1_valid, m0_valid} & {2{(state == ST_IDLE) && !rst && !rst_hold}};

   rr_arb2 u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign m0_ready   = grant[0];
   assign m1_ready   = grant[1];
   assign g_write    = grant[1] ? m1_write : m0_write;
   assign g_addr     = grant[1] ? m1_addr  : m0_addr;
   assign g_in_range = ({1'b0, g_addr} < ENTRIES_L);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant   <= 1'b1;
         rst_hold     <= 1'b1;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         wait_cnt     <= '0;
         beat         <= '0;
         resp_q       <= '0;
         err_q        <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         rst_hold    <= 1'b0;
         resp_q      <= '0;
         err_q       <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  owner_q    <= grant[1];
                  last_grant <= grant[1];
                  addr_q     <= g_addr;
                  be_q       <= grant[1] ? m1_be : m0_be;
                  wdata_q    <= grant[1] ? m1_wdata : m0_wdata;
                  if (!g_in_range) begin
                     state             <= ST_RESP;
                     resp_q[grant[1]]  <= 1'b1;
                     err_q[grant[1]]   <= 1'b1;
                     err_sticky_q      <= 1'b1;
                  end else if (g_write) begin
                     state       <= ST_WR_ISSUE;
                     mem_write_q <= 1'b1;
                     beat        <= 2'd0;
                  end else begin
                     state      <= ST_RD_ISSUE;
                     mem_read_q <= 1'b1;
                  end
               end
            end
            ST_RD_ISSUE: begin
               state    <= ST_RD_WAIT;
               wait_cnt <= '0;
            end
            ST_RD_WAIT: begin
               if (mem_valid) begin
                  state           <= ST_RESP;
                  rdata_q         <= mem_rd;
                  resp_q[owner_q] <= 1'b1;
               end else if (wait_cnt == WAIT_LAST) begin
                  state           <= ST_RESP;
                  resp_q[owner_q] <= 1'b1;
                  err_q[owner_q]  <= 1'b1;
                  err_sticky_q    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_WR_ISSUE: begin
               // Second beat repeats the same address/data; leave after it.
               if (beat == 2'd0) begin
                  beat        <= 2'd1;
                  mem_write_q <= 1'b1;
               end else begin
                  state    <= ST_WR_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_WR_WAIT: begin
               if (mem_ready) begin
                  state           <= ST_RESP;
                  resp_q[owner_q] <= 1'b1;
               end else if (wait_cnt == WAIT_LAST) begin
                  state           <= ST_RESP;
                  resp_q[owner_q] <= 1'b1;
                  err_q[owner_q]  <= 1'b1;
                  err_sticky_q    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign m0_resp    = resp_q[0];
   assign m1_resp    = resp_q[1];
   assign m0_err     = err_q[0];
   assign m1_err     = err_q[1];
   assign m0_rdata   = rdata_q;
   assign m1_rdata   = rdata_q;
   assign mem_a      = addr_q;
   assign mem_be     = be_q;
   assign mem_wd     = wdata_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign err_sticky = err_sticky_q;
   assign state_dbg  = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a line-memory reference and a round-robin model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int ENT = 256;
   localparam int EW  = 259;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              m0_valid = 1'b0, m1_valid = 1'b0;
   logic              m0_ready, m1_ready;
   logic              m0_write = 1'b0, m1_write = 1'b0;
   logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
   logic [BE_W-1:0]   m0_be = '0, m1_be = '0;
   logic [LINE_W-1:0] m0_wdata = '0, m1_wdata = '0;
   logic              m0_resp, m1_resp, m0_err, m1_err;
   logic [LINE_W-1:0] m0_rdata, m1_rdata;
   logic [ADDR_W-1:0] mem_a;
   logic [BE_W-1:0]   mem_be;
   logic [LINE_W-1:0] mem_wd;
   logic              mem_read, mem_write;
   logic [LINE_W-1:0] mem_rd = '0;
   logic              mem_valid, mem_ready;
   logic              err_sticky;
   logic [2:0]        state_dbg;

   mem_arbiter #(.ENTRIES(ENT), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write), .m0_addr(m0_addr),
      .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_resp(m0_resp), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write), .m1_addr(m1_addr),
      .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_resp(m1_resp), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .err_sticky(err_sticky), .state_dbg(state_dbg)
   );

   // clock / cycle count
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // memory model: mem_valid/mem_ready two cycles after the first strobe cycle
   logic [LINE_W-1:0] tb_mem  [0:ENT-1];
   logic [LINE_W-1:0] ref_mem [0:ENT-1];
   logic mdl_valid = 1'b0, mdl_ready = 1'b0, inj_valid = 1'b0, inj_ready = 1'b0;
   logic suppress_valid = 1'b0, suppress_ready = 1'b0;
   assign mem_valid = mdl_valid | inj_valid;
   assign mem_ready = mdl_ready | inj_ready;

   int rd_cd = 0, wr_cd = 0, burst = 0;
   int rd_cnt = 0, wr_beats = 0, rd_cyc = -1, wr_cyc = -1;
   logic prev_wr = 1'b0;
   logic [ADDR_W-1:0] rd_addr_l, la;
   logic [BE_W-1:0]   lbe;
   logic [LINE_W-1:0] lwd;

   always @(negedge clk) begin
      mdl_valid = 1'b0;
      mdl_ready = 1'b0;
      if (rd_cd == 1 && !suppress_valid) begin
         mdl_valid = 1'b1;
         mem_rd    = tb_mem[rd_addr_l[7:0]];
      end
      if (rd_cd > 0) rd_cd--;
      if (wr_cd == 1 && !suppress_ready) mdl_ready = 1'b1;
      if (wr_cd > 0) wr_cd--;
      if (mem_read || mem_write) chk("rd_wr_exclusive", EW'(mem_read & mem_write), EW'(0));
      if (mem_read) begin
         rd_cnt++;
         rd_cyc    = cyc;
         rd_addr_l = mem_a;
         rd_cd     = 2;
         chk("rd_in_range", EW'(int'(mem_a) < ENT), EW'(1));
      end
      if (mem_write) begin
         wr_beats++;
         if (!prev_wr) begin
            burst  = 1;
            wr_cyc = cyc;
            wr_cd  = 2;
            la = mem_a; lbe = mem_be; lwd = mem_wd;
            chk("wr_in_range", EW'(int'(mem_a) < ENT), EW'(1));
            for (int b = 0; b < BE_W; b++)
               if (mem_be[b]) tb_mem[mem_a[7:0]][b*8 +: 8] = mem_wd[b*8 +: 8];
         end else begin
            burst++;
            chk("wr_beat_stable", EW'({mem_a, mem_be, mem_wd} === {la, lbe, lwd}), EW'(1));
         end
      end else if (prev_wr) begin
         chk("wr_burst_len", EW'(burst), EW'(2));
      end
      prev_wr = mem_write;
   end

   // scoreboard: {rdata_checked, owner, err, rdata}
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   logic          mon_owner, mon_err;
   logic [LINE_W-1:0] mon_rdata;
   int resp_cyc = -1, resp_count = 0;

   always @(negedge clk) begin
      if (!rst && (m0_resp || m1_resp)) begin
         resp_cyc = cyc;
         resp_count++;
         chk("resp_onehot", EW'(m0_resp & m1_resp), EW'(0));
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", EW'({m1_resp, m0_resp}), EW'(0));
         end else begin
            mon_e     = exp_q.pop_front();
            mon_owner = m1_resp;
            mon_err   = mon_owner ? m1_err : m0_err;
            mon_rdata = mon_owner ? m1_rdata : m0_rdata;
            chk("resp_owner", EW'(mon_owner), EW'(mon_e[257]));
            chk("resp_err", EW'(mon_err), EW'(mon_e[256]));
            if (mon_e[258]) chk("resp_rdata", EW'(mon_rdata), EW'(mon_e[255:0]));
         end
      end
   end

   // reference model state
   int   rr_last = 1;
   int   acc_cyc = -1;
   logic expect_timeout = 1'b0;
   logic exp_sticky = 1'b0;

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   task automatic set_req(input int port, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [BE_W-1:0] be, input logic [LINE_W-1:0] wd);
      if (port == 0) begin
         m0_write = w; m0_addr = a; m0_be = be; m0_wdata = wd;
      end else begin
         m1_write = w; m1_addr = a; m1_be = be; m1_wdata = wd;
      end
   endtask

   task automatic book(input int who);
      logic              w, err;
      logic [ADDR_W-1:0] a;
      logic [BE_W-1:0]   be;
      logic [LINE_W-1:0] wd;
      logic [EW-1:0]     e;
      w  = (who == 1) ? m1_write : m0_write;
      a  = (who == 1) ? m1_addr  : m0_addr;
      be = (who == 1) ? m1_be    : m0_be;
      wd = (who == 1) ? m1_wdata : m0_wdata;
      err = (int'(a) >= ENT) || expect_timeout;
      e = '0;
      e[257] = (who == 1);
      e[256] = err;
      e[258] = !w && !err;
      if (int'(a) < ENT) begin
         if (!w) e[255:0] = ref_mem[a[7:0]];
         else
            for (int b = 0; b < BE_W; b++)
               if (be[b]) ref_mem[a[7:0]][b*8 +: 8] = wd[b*8 +: 8];
      end
      if (err) exp_sticky = 1'b1;
      exp_q.push_back(e);
      rr_last = who;
      acc_cyc = cyc;
   endtask

   // driver: raise the wanted valids, wait for an accept, drop only the winner
   task automatic issue(input bit want0, input bit want1, output int who);
      int exp_who;
      who = -1;
      m0_valid = want0;
      m1_valid = want1;
      for (int t = 0; t < 80 && who < 0; t++) begin
         #1;
         if (m0_ready || m1_ready) begin
            exp_who = (want0 && want1) ? ((rr_last == 1) ? 0 : 1) : (want1 ? 1 : 0);
            chk("grant", EW'({m1_ready, m0_ready}), EW'((exp_who == 1) ? 2'b10 : 2'b01));
            who = m1_ready ? 1 : 0;
            book(who);
         end
         @(negedge clk);
      end
      if (who < 0) chk("accept_timeout", EW'(1), EW'(0));
      if (who == 0) m0_valid = 1'b0;
      if (who == 1) m1_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
      chk("drain", EW'(exp_q.size()), EW'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int w, w2, rd0, wb0, rc0, mode, port;
   logic [2:0] order;
   logic [ADDR_W-1:0] ra;

   initial begin
      for (int i = 0; i < ENT; i++) begin
         tb_mem[i]  = {8{32'(i) * 32'h9E37_79B9}};
         ref_mem[i] = tb_mem[i];
      end
      tb_mem[16]  = {32{8'hA5}};
      ref_mem[16] = {32{8'hA5}};

      // reset
      rst = 1'b1;
      @(negedge clk);
      chk("reset_outputs", EW'({m0_ready, m1_ready, m0_resp, m1_resp, m0_err, m1_err,
                                mem_read, mem_write, err_sticky}), EW'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // m0 read of preloaded line
      rd0 = rd_cnt;
      set_req(0, 1'b0, 27'h10, '0, '0);
      issue(1, 0, w);
      drain();
      chk("t036_rd_strobes", EW'(rd_cnt - rd0), EW'(1));
      chk("t036_latency", EW'(resp_cyc - rd_cyc), EW'(3));
      chk("t036_sticky", EW'(err_sticky), EW'(0));

      // m1 full-line write then read back
      wb0 = wr_beats;
      set_req(1, 1'b1, 27'h3, '1, {32{8'h5A}});
      issue(0, 1, w);
      drain();
      chk("t037_wr_beats", EW'(wr_beats - wb0), EW'(2));
      chk("t037_wr_latency", EW'(resp_cyc - wr_cyc), EW'(3));
      set_req(1, 1'b0, 27'h3, '0, '0);
      issue(0, 1, w);
      drain();

      // three tie rounds
      set_req(0, 1'b0, 27'h20, '0, '0);
      set_req(1, 1'b0, 27'h21, '0, '0);
      for (int r = 0; r < 3; r++) begin
         issue(1, 1, w);
         order[2-r] = (w == 1);
         set_req(w, 1'b0, ADDR_W'(32 + r), '0, '0);
      end
      chk("t038_order", EW'(order), EW'(3'b010));
      issue(0, 1, w);
      drain();

      // out-of-range read
      rd0 = rd_cnt; wb0 = wr_beats;
      set_req(0, 1'b0, 27'd256, '0, '0);
      issue(1, 0, w);
      drain();
      chk("t039_resp_next_cycle", EW'(resp_cyc - acc_cyc), EW'(1));
      chk("t039_no_strobe", EW'((rd_cnt - rd0) + (wr_beats - wb0)), EW'(0));
      chk("t039_sticky", EW'(err_sticky), EW'(1));

      // read timeout, then a late mem_valid
      suppress_valid = 1'b1;
      expect_timeout = 1'b1;
      set_req(0, 1'b0, 27'h5, '0, '0);
      issue(1, 0, w);
      expect_timeout = 1'b0;
      drain();
      chk("t040_timeout_cycles", EW'(resp_cyc - (rd_cyc + 1)), EW'(15));
      suppress_valid = 1'b0;
      repeat (2) @(negedge clk);
      rc0 = resp_count;
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t040_late_ignored", EW'(resp_count - rc0), EW'(0));

      // reset during WR_WAIT
      suppress_ready = 1'b1;
      set_req(1, 1'b1, 27'h7, '1, rand_line());
      issue(0, 1, w);
      repeat (3) @(negedge clk);
      rc0 = resp_count;
      rst = 1'b1;
      @(negedge clk);
      chk("t041_reset_outputs", EW'({m0_ready, m1_ready, m0_resp, m1_resp, m0_err, m1_err,
                                     mem_read, mem_write, err_sticky}), EW'(0));
      exp_q.delete();
      rr_last = 1;
      exp_sticky = 1'b0;
      rst = 1'b0;
      suppress_ready = 1'b0;
      inj_ready = 1'b1;
      @(negedge clk);
      inj_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("t041_no_resp", EW'(resp_count - rc0), EW'(0));
      set_req(1, 1'b0, 27'h7, '0, '0);
      issue(0, 1, w);
      drain();
      set_req(1, 1'b1, 27'h8, 32'h0F0F_F0F0, rand_line());
      issue(0, 1, w);
      drain();
      set_req(1, 1'b0, 27'h8, '0, '0);
      issue(0, 1, w);
      drain();
      chk("t041_sticky_clear", EW'(err_sticky), EW'(0));

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(0, 2);
         for (int p = 0; p < 2; p++) begin
            ra = ($urandom_range(0, 9) == 0) ? ADDR_W'(256 + $urandom_range(0, 1000))
                                              : ADDR_W'($urandom_range(0, 15));
            set_req(p, 1'($urandom_range(0, 1)), ra, $urandom(), rand_line());
         end
         if (mode == 2) begin
            issue(1, 1, w);
            issue(w == 1, w == 0, w2);
         end else begin
            port = mode;
            issue(port == 0, port == 1, w);
         end
         drain();
         chk("rand_sticky", EW'(err_sticky), EW'(exp_sticky));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ENTRIES, 256, main memory depth in 256-bit lines; line addresses >= ENTRIES are out of range.
REQ-002 Parameter: TIMEOUT, 15, max cycles in a wait state before the transaction is forced complete with error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mN_valid  input  1  requester N (N=0,1) request present; held until accepted.
REQ-006 mN_ready  output  1  requester N request accepted this cycle when mN_valid also high.
REQ-007 mN_write  input  1  1 = line write, 0 = line read.
REQ-008 mN_addr  input  27  line address.
REQ-009 mN_be  input  32  byte enables for writes.
REQ-010 mN_wdata  input  256  write line data.
REQ-011 mN_resp  output  1  one-cycle completion pulse to requester N.
REQ-012 mN_err  output  1  qualifies mN_resp: timeout or out-of-range.
REQ-013 mN_rdata  output  256  read line; valid only with mN_resp of a read without error.
REQ-014 mem_a / mem_be / mem_wd  output  27/32/256  memory address, byte enables, write data.
REQ-015 mem_read / mem_write  output  1/1  memory strobes.
REQ-016 mem_rd / mem_valid / mem_ready  input  256/1/1  memory read data, read-data valid, write done.
REQ-017 err_sticky  output  1  set on any error completion; cleared only by rst.

Function
REQ-018 One transaction in flight; requests accepted only in IDLE.
REQ-019 In IDLE, mN_ready = 1 for exactly the granted requester with mN_valid high; otherwise 0.
REQ-020 Arbitration round-robin: single requester granted directly; both valid -> grant the one not granted last; last-grant resets to 1 (m0 wins first tie).
REQ-021 On accept, addr/be/wdata/write/owner latch into internal registers; mem_* driven from latched values only.
REQ-022 Out-of-range addr (>= ENTRIES): no memory strobe; owner gets mN_resp=1, mN_err=1 in the cycle after accept; return to IDLE.
REQ-023 States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP.
REQ-024 RD_ISSUE: exactly one cycle with mem_read=1 -> RD_WAIT.
REQ-025 WR_ISSUE: mem_write=1 for exactly two consecutive cycles, mem_a/mem_be/mem_wd stable across both (2-bit beat counter) -> WR_WAIT.
REQ-026 RD_WAIT: on mem_valid, capture mem_rd -> RESP; WR_WAIT: on mem_ready -> RESP.
REQ-027 Nominal latency: mem_valid 2 cycles after the mem_read cycle; mem_ready 2 cycles after the first mem_write cycle.
REQ-028 Wait counter clears on wait-state entry, increments per cycle; if it reaches TIMEOUT with no mem_valid/mem_ready -> RESP with error.
REQ-029 RESP: one cycle, owner mN_resp=1 with rdata/err; non-owner resp=0 -> IDLE; new accept earliest the cycle after RESP.
REQ-030 mem_valid/mem_ready outside the matching wait state ignored (no response, no error).
REQ-031 mem_read and mem_write never high together; both 0 in IDLE, RESP, wait states.

Reset
REQ-032 rst forces IDLE, clears counters, last-grant=1, err_sticky=0; all mN_ready, mN_resp, mN_err, mem_read, mem_write = 0 in the cycle after rst sampled high.
REQ-033 rst mid-transaction abandons it without response; subsequent late mem_valid/mem_ready ignored per REQ-030.

Structure
REQ-034 Shared package holds FSM state encoding, line/addr/be widths (256/27/32), default TIMEOUT.
REQ-035 Round-robin grant logic is one sub-module, rr_arb2 (two requests, last-grant input, one-hot grant out); rest flat.

Verification
REQ-036 m0 read addr 0x10, memory preloaded 0xA5.. -> mem_read 1 cycle, m0_resp 3 cycles after mem_read cycle, m0_rdata=0xA5.., m0_err=0.
REQ-037 m1 write addr 0x3, be=all-ones, wdata=0x5A..; then m1 read 0x3 -> mem_write exactly 2 cycles, read returns 0x5A...
REQ-038 m0 and m1 valid in same cycle, three back-to-back rounds -> grant order m0, m1, m0; non-granted ready stays 0.
REQ-039 m0 read addr 256 (ENTRIES=256) -> no mem strobe, m0_resp+m0_err next cycle, err_sticky=1.
REQ-040 Memory model suppresses mem_valid -> m0_resp with m0_err exactly TIMEOUT=15 cycles after RD_WAIT entry; then late mem_valid ignored.
REQ-041 rst asserted during WR_WAIT -> no resp; outputs 0 next cycle; next m1 request served normally.
